// File: rtl/cpu6_ifu_if.sv
// Fetch-unit bundle: EX redirect, instruction-memory req/gnt/rvalid and the
// valid/ready presentation of pcE/instrE to EX.
interface cpu6_ifu_if #(
  parameter int XLEN = 32
);
  logic            pcsrcE;
  logic [XLEN-1:0] pcnextE;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            validE;
  logic [XLEN-1:0] pcE;
  logic [31:0]     instrE;
  logic            readyE;

  modport master (
    input  pcsrcE, pcnextE, imem_gnt, imem_rvalid, imem_rdata, readyE,
    output imem_req, imem_addr, validE, pcE, instrE
  );

  modport slave (
    output pcsrcE, pcnextE, imem_gnt, imem_rvalid, imem_rdata, readyE,
    input  imem_req, imem_addr, validE, pcE, instrE
  );
endinterface

// File: rtl/cpu6_ifu.sv
// Instruction fetch unit: credit-limited in-order fetch into a small queue
// of {pc, instr}, with EX redirect flushing the queue and dropping stale fetches.
module cpu6_ifu #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter int              CNT_W      = 2
) (
  input logic        clk,
  input logic        reset,
  cpu6_ifu_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [XLEN-1:0]  r_pc_f;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [XLEN-1:0]  r_q_pc    [FIFO_DEPTH];
  logic [31:0]      r_q_instr [FIFO_DEPTH];

  logic             w_redirect;
  logic             w_valid;
  logic             w_pop;
  logic             w_grant;
  logic             w_push;
  logic [CNT_W:0]   w_inflight;
  logic [XLEN-1:0]  w_target;

  assign w_redirect = bus.pcsrcE;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & bus.readyE & ~w_redirect;
  assign w_grant    = bus.imem_req & bus.imem_gnt;
  assign w_push     = bus.imem_rvalid & (r_drop_cnt == '0) & ~w_redirect;
  assign w_target   = bus.pcnextE & ~(XLEN'(3));

  // Credit: queued + in-flight after this cycle's pop must leave room for one more.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding} - {{CNT_W{1'b0}}, w_pop};

  assign bus.imem_req  = ~reset & ~w_redirect & (w_inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign bus.imem_addr = r_pc_f;
  assign bus.validE    = w_valid;
  assign bus.pcE       = r_q_pc[r_rd_ptr];
  assign bus.instrE    = r_q_instr[r_rd_ptr];

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking would let later statements see half-updated state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f        <= RESET_PC & ~(XLEN'(3));
      r_resp_pc     <= RESET_PC & ~(XLEN'(3));
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      // NOTE: the queue storage is reset on purpose so pcE/instrE read 0 out of
      // reset; this is only affordable because the queue is a handful of flops.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_redirect) begin
      r_pc_f        <= w_target;
      r_resp_pc     <= w_target;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= r_outstanding - CNT_W'(bus.imem_rvalid);
      r_drop_cnt    <= r_outstanding - CNT_W'(bus.imem_rvalid);
    end else begin
      if (w_grant) begin
        r_pc_f <= r_pc_f + XLEN'(4);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(bus.imem_rvalid);
      if (bus.imem_rvalid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
      if (w_push) begin
        r_q_pc[r_wr_ptr]    <= r_resp_pc;
        r_q_instr[r_wr_ptr] <= bus.imem_rdata;
        r_resp_pc           <= r_resp_pc + XLEN'(4);
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
endmodule

// File: tb/tb_cpu6_ifu.sv
// Randomized bench for cpu6_ifu: a memory model answers fetches, an
// epoch-tagged reference model predicts the presented stream, a monitor checks.
module tb_cpu6_ifu;
  localparam int          XLEN       = 32;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int          FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu6_ifu_if #(.XLEN(XLEN)) bus ();

  cpu6_ifu #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          gcyc;
  } fetch_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  fetch_t      pend[$];
  exp_t        sb[$];
  int          epoch;
  int          cyc;
  logic [31:0] fetch_pc;

  logic        exp_req;
  logic [31:0] exp_addr;
  logic        prev_grant, prev_rvalid, prev_redir;
  logic [31:0] prev_target, prev_addr;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ (a * 32'd2654435761);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply the architectural effect of the cycle that just ended.
  task automatic commit();
    fetch_t e;
    if (prev_rvalid) begin
      e = pend.pop_front();
      if (!prev_redir && e.epoch == epoch) sb.push_back('{e.addr, mem(e.addr)});
    end
    if (prev_redir) begin
      sb.delete();
      epoch++;
      fetch_pc = prev_target & ~32'h3;
    end
    if (prev_grant) begin
      pend.push_back('{prev_addr, epoch, cyc});
      fetch_pc = fetch_pc + 32'd4;
    end
  endtask

  task automatic predict();
    int pop_m;
    pop_m    = (sb.size() != 0 && bus.readyE && !bus.pcsrcE) ? 1 : 0;
    exp_req  = !bus.pcsrcE && (sb.size() + pend.size() - pop_m < FIFO_DEPTH);
    exp_addr = fetch_pc;
    prev_grant  = exp_req && bus.imem_gnt;
    prev_addr   = fetch_pc;
    prev_rvalid = bus.imem_rvalid;
    prev_redir  = bus.pcsrcE;
    prev_target = bus.pcnextE;
  endtask

  task automatic do_cycle(input int pg, input int pr, input int py, input int pd);
    @(posedge clk);
    #1;
    commit();
    cyc++;
    bus.pcsrcE = ($urandom_range(99) < pd);
    case ($urandom_range(4))
      0:       bus.pcnextE = 32'h0000_0100;
      1:       bus.pcnextE = 32'h0000_0203;
      2:       bus.pcnextE = 32'hFFFF_FFF8;
      3:       bus.pcnextE = 32'hFFFF_FFFC;
      default: bus.pcnextE = $urandom;
    endcase
    bus.readyE   = ($urandom_range(99) < pr);
    bus.imem_gnt = ($urandom_range(99) < pg);
    if (pend.size() > 0 && pend[0].gcyc < cyc && $urandom_range(99) < py) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem(pend[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    predict();
  endtask

  task automatic idle_inputs();
    bus.pcsrcE      = 1'b0;
    bus.pcnextE     = '0;
    bus.readyE      = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
  endtask

  task automatic clear_model();
    pend.delete();
    sb.delete();
    epoch    = 0;
    fetch_pc = RESET_PC;
    prev_grant = 1'b0; prev_rvalid = 1'b0; prev_redir = 1'b0;
    prev_target = '0;  prev_addr = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    idle_inputs();
    predict();
  endtask

  // Monitor: compares DUT outputs against the model each cycle, pops on handshake.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_req",    {31'b0, bus.imem_req}, 32'h0);
      check("rst_validE", {31'b0, bus.validE},   32'h0);
      check("rst_pcE",    bus.pcE,               32'h0);
      check("rst_instrE", bus.instrE,            32'h0);
      check("rst_addr",   bus.imem_addr,         RESET_PC);
    end else begin
      check("validE", {31'b0, bus.validE}, {31'b0, (sb.size() != 0)});
      if (sb.size() != 0) begin
        check("pcE",    bus.pcE,    sb[0].pc);
        check("instrE", bus.instrE, sb[0].instr);
      end
      check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
      if (exp_req) check("imem_addr", bus.imem_addr, exp_addr);
      if (sb.size() != 0 && bus.readyE && !bus.pcsrcE) begin
        void'(sb.pop_front());
        n_pop++;
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    cyc   = 0;
    idle_inputs();
    clear_model();
    exp_req = 1'b0; exp_addr = RESET_PC;
    repeat (3) @(posedge clk);
    release_reset();

    // Full-rate streaming: expect roughly one instruction per cycle.
    n_pop = 0;
    repeat (19) do_cycle(100, 100, 100, 0);
    @(negedge clk); #1;
    check("throughput", (n_pop >= 17) ? 32'd1 : 32'd0, 32'd1);

    // Stall EX, then resume.
    repeat (6)  do_cycle(100, 0, 100, 0);
    check("stall_full", sb.size(), FIFO_DEPTH);
    repeat (10) do_cycle(100, 100, 100, 0);

    // Randomized traffic with redirects, stalls and slow memory.
    repeat (1500) do_cycle(60, 70, 60, 5);

    // Fill the queue, then assert reset mid-operation.
    waited = 0;
    while (sb.size() < FIFO_DEPTH && waited < 50) begin
      do_cycle(100, 0, 100, 0);
      waited++;
    end
    check("prefill_valid", {31'b0, bus.validE}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    clear_model();
    #1;
    check("async_validE", {31'b0, bus.validE},   32'h0);
    check("async_req",    {31'b0, bus.imem_req}, 32'h0);
    repeat (2) @(posedge clk);
    release_reset();

    repeat (500) do_cycle(70, 60, 70, 4);
    repeat (20)  do_cycle(100, 100, 100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
